core_run_ctrl: RTL

CORE_RUN_CTRL -- requirements
Module: core_run_ctrl

---
 rtl/core_ctrl_pkg.sv | 27 ++
 rtl/imem_load_seq.sv | 65 ++++++
 rtl/core_run_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/core_ctrl_pkg.sv
// ============================================================================
// Module  : core_ctrl_pkg
// Brief   : Shared run-controller FSM encoding and instruction-size helper.
// Revision: 1.0
// ============================================================================
`default_nettype none

package core_ctrl_pkg;

  localparam int c_STATE_W = 3;

  typedef enum logic [c_STATE_W-1:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_INIT = 3'd2,
    ST_HALT = 3'd3,
    ST_RUN  = 3'd4,
    ST_STEP = 3'd5
  } state_t;

  function automatic int instr_bytes(input int reg_bits);
    return reg_bits / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/imem_load_seq.sv
// ============================================================================
// Module  : imem_load_seq
// Brief   : Loader byte address sequencer with overflow and alignment checks.
// Revision: 1.0
// ============================================================================
`default_nettype none

module imem_load_seq #(
  parameter int IMEM_BYTES  = 256,
  parameter int INSTR_BYTES = 4,
  parameter int AW          = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_clr,
  input  logic          i_active,
  input  logic          i_valid,
  input  logic          i_last,
  output logic          o_we,
  output logic [AW-1:0] o_addr,
  output logic          o_err
);

  localparam logic [AW-1:0] c_LAST_ADDR  = AW'(IMEM_BYTES - 1);
  localparam logic [AW-1:0] c_ALIGN_MASK = AW'(INSTR_BYTES - 1);

  logic [AW-1:0] r_addr;
  logic          r_ovf;
  logic          r_err;
  logic          w_accept;
  logic          w_at_end;
  logic          w_misaligned;

  assign w_accept     = i_active & i_valid;
  assign w_at_end     = (r_addr == c_LAST_ADDR);
  // Byte count at ld_last is r_addr+1, so it is whole-instruction only when
  // the low address bits are all ones.
  assign w_misaligned = ((r_addr & c_ALIGN_MASK) != c_ALIGN_MASK);

  always_ff @(posedge clk) begin
    if (!reset_n || i_clr) begin
      r_addr <= '0;
      r_ovf  <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_accept && !r_ovf) begin
      if (i_last) begin
        if (w_misaligned) begin
          r_err <= 1'b1;
        end
      end else if (w_at_end) begin
        r_ovf <= 1'b1;
        r_err <= 1'b1;
      end else begin
        r_addr <= r_addr + 1'b1;
      end
    end
  end

  assign o_we   = w_accept & ~r_ovf;
  assign o_addr = r_addr;
  assign o_err  = r_err;

endmodule

`default_nettype wire

// File: rtl/core_run_ctrl.sv
// ============================================================================
// Module  : core_run_ctrl
// Brief   : Program loader and run/step/halt controller for the stack core.
// Revision: 1.0
// ============================================================================
`default_nettype none

module core_run_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int REG_BITS   = 32,
  parameter int IMEM_BYTES = 256
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          ld_valid,
  input  logic [7:0]                    ld_data,
  input  logic                          ld_last,
  output logic                          ld_ready,
  input  logic                          cmd_run,
  input  logic                          cmd_step,
  input  logic                          cmd_halt,
  output logic                          imem_we,
  output logic [$clog2(IMEM_BYTES)-1:0] imem_waddr,
  output logic [7:0]                    imem_wdata,
  output logic                          core_init,
  output logic                          core_en,
  output logic [2:0]                    state_o,
  output logic [31:0]                   instr_count,
  output logic                          load_err
);

  localparam int INSTR_BYTES = instr_bytes(REG_BITS);
  localparam int AW          = $clog2(IMEM_BYTES);

  state_t        r_state;
  state_t        w_next;
  logic          w_clr;
  logic          w_seq_we;
  logic [31:0]   r_instr_count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    case (r_state)
      ST_IDLE: if (ld_valid) w_next = ST_LOAD;
      ST_LOAD: if (ld_valid && ld_last) w_next = ST_INIT;
      ST_INIT: w_next = ST_HALT;
      ST_HALT: begin
        if (cmd_halt) begin
          w_next = ST_HALT;
        end else if (cmd_step) begin
          w_next = ST_STEP;
        end else if (cmd_run) begin
          w_next = ST_RUN;
        end else if (ld_valid) begin
          w_next = ST_LOAD;
          w_clr  = 1'b1;
        end
      end
      ST_RUN:  if (cmd_halt) w_next = ST_HALT;
      ST_STEP: w_next = ST_HALT;
      default: w_next = ST_IDLE;
    endcase
  end

  imem_load_seq #(
    .IMEM_BYTES  (IMEM_BYTES),
    .INSTR_BYTES (INSTR_BYTES),
    .AW          (AW)
  ) u_load_seq (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_clr    (w_clr),
    .i_active (r_state == ST_LOAD),
    .i_valid  (ld_valid),
    .i_last   (ld_last),
    .o_we     (w_seq_we),
    .o_addr   (imem_waddr),
    .o_err    (load_err)
  );

  // Strobes are masked by reset_n so an abort in the reset cycle itself
  // cannot leak a final imem write or core_en pulse.
  assign ld_ready   = reset_n & (r_state == ST_LOAD);
  assign imem_we    = reset_n & w_seq_we;
  assign imem_wdata = ld_data;
  assign core_init  = reset_n & (r_state == ST_INIT);
  assign core_en    = reset_n & ((r_state == ST_RUN) | (r_state == ST_STEP));
  assign state_o    = r_state;

  always_ff @(posedge clk) begin
    if (!reset_n || core_init) begin
      r_instr_count <= '0;
    end else if (core_en) begin
      r_instr_count <= r_instr_count + 32'd1;
    end
  end

  assign instr_count = r_instr_count;

endmodule

`default_nettype wire
